// File: rtl/ex_alu_stage_if.sv
// EX-stage bus: instruction/operand inputs from decode and the registered EX/MEM outputs.
// The master side drives the instruction; the slave side (the ALU stage) drives the results.
interface ex_alu_stage_if #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
);
  logic               in_valid;
  logic               stall;
  logic               flush;
  logic [3:0]         alu_ctrl;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               is_beq;
  logic               is_bne;
  logic [RD_BITS-1:0] rd_in;
  logic               reg_write_in;

  logic               out_valid;
  logic [WIDTH-1:0]   alu_result;
  logic               zero;
  logic               overflow;
  logic               illegal;
  logic               branch_taken;
  logic [RD_BITS-1:0] rd_out;
  logic               reg_write_out;

  modport master (
    output in_valid, stall, flush, alu_ctrl, op_a, op_b,
           is_beq, is_bne, rd_in, reg_write_in,
    input  out_valid, alu_result, zero, overflow, illegal,
           branch_taken, rd_out, reg_write_out
  );

  modport slave (
    input  in_valid, stall, flush, alu_ctrl, op_a, op_b,
           is_beq, is_bne, rd_in, reg_write_in,
    output out_valid, alu_result, zero, overflow, illegal,
           branch_taken, rd_out, reg_write_out
  );
endinterface

// File: rtl/ex_alu_stage.sv
// Execute-stage ALU with branch resolution and the EX/MEM pipeline register.
// Priority at each edge: reset > flush > stall > capture; a non-valid capture is a bubble.
module ex_alu_stage #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
) (
  input logic          clk,
  input logic          reset,
  ex_alu_stage_if.slave bus
);

  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_ovfAdd;
  logic               w_ovfSub;
  logic               w_slt;
  logic [WIDTH-1:0]   w_result;
  logic               w_overflow;
  logic               w_badCode;
  logic               w_illegal;
  logic               w_zero;
  logic               w_branch;
  logic               w_regWrite;

  logic               r_outValid;
  logic [WIDTH-1:0]   r_aluResult;
  logic               r_zero;
  logic               r_overflow;
  logic               r_illegal;
  logic               r_branchTaken;
  logic [RD_BITS-1:0] r_rdOut;
  logic               r_regWrite;

  assign w_sum    = bus.op_a + bus.op_b;
  assign w_diff   = bus.op_a - bus.op_b;
  assign w_ovfAdd = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                    (w_sum[WIDTH-1]    != bus.op_a[WIDTH-1]);
  assign w_ovfSub = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                    (w_diff[WIDTH-1]   != bus.op_a[WIDTH-1]);
  // Correcting the difference sign with the overflow bit keeps SLT exact at the extremes.
  assign w_slt    = w_diff[WIDTH-1] ^ w_ovfSub;

  always_comb begin
    w_result   = '0;
    w_overflow = 1'b0;
    w_badCode  = 1'b0;
    case (bus.alu_ctrl)
      4'b0000: begin
        w_result   = w_sum;
        w_overflow = w_ovfAdd;
      end
      4'b0001: begin
        w_result   = w_diff;
        w_overflow = w_ovfSub;
      end
      4'b0010: w_result = bus.op_a & bus.op_b;
      4'b0011: w_result = bus.op_a | bus.op_b;
      4'b0100: w_result = bus.op_a ^ bus.op_b;
      4'b0101: w_result = ~(bus.op_a | bus.op_b);
      4'b0110: w_result = {{(WIDTH-1){1'b0}}, w_slt};
      default: w_badCode = 1'b1;
    endcase
  end

  // A BEQ and BNE asserted together is a malformed decode, reported as illegal.
  assign w_illegal  = w_badCode || (bus.is_beq && bus.is_bne);
  assign w_zero     = (w_result == '0);
  assign w_branch   = !w_illegal &&
                      ((bus.is_beq && w_zero) || (bus.is_bne && !w_zero));
  assign w_regWrite = bus.reg_write_in && !w_overflow && !w_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid    <= 1'b0;
      r_aluResult   <= '0;
      r_zero        <= 1'b0;
      r_overflow    <= 1'b0;
      r_illegal     <= 1'b0;
      r_branchTaken <= 1'b0;
      r_rdOut       <= '0;
      r_regWrite    <= 1'b0;
    end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
      r_outValid    <= 1'b0;
      r_aluResult   <= '0;
      r_zero        <= 1'b0;
      r_overflow    <= 1'b0;
      r_illegal     <= 1'b0;
      r_branchTaken <= 1'b0;
      r_rdOut       <= '0;
      r_regWrite    <= 1'b0;
    end else if (!bus.stall) begin
      r_outValid    <= 1'b1;
      r_aluResult   <= w_result;
      r_zero        <= w_zero;
      r_overflow    <= w_overflow;
      r_illegal     <= w_illegal;
      r_branchTaken <= w_branch;
      r_rdOut       <= bus.rd_in;
      r_regWrite    <= w_regWrite;
    end
  end

  assign bus.out_valid     = r_outValid;
  assign bus.alu_result    = r_aluResult;
  assign bus.zero          = r_zero;
  assign bus.overflow      = r_overflow;
  assign bus.illegal       = r_illegal;
  assign bus.branch_taken  = r_branchTaken;
  assign bus.rd_out        = r_rdOut;
  assign bus.reg_write_out = r_regWrite;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed-vector bench for ex_alu_stage; expected values are worked out by hand.
module tb_ex_alu_stage;

  logic clk;
  logic reset;
  int   assertCount;
  int   failCount;

  ex_alu_stage_if #(.WIDTH(32), .RD_BITS(5)) bus ();

  ex_alu_stage #(.WIDTH(32), .RD_BITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic expectAll(input string tag, input logic valid, input logic [31:0] result,
                           input logic zero, input logic ovf, input logic ill,
                           input logic bt, input logic [4:0] rd, input logic rw);
    checkOutput({tag, ".valid"},  {31'd0, bus.out_valid},     {31'd0, valid});
    checkOutput({tag, ".result"}, bus.alu_result,             result);
    checkOutput({tag, ".zero"},   {31'd0, bus.zero},          {31'd0, zero});
    checkOutput({tag, ".ovf"},    {31'd0, bus.overflow},      {31'd0, ovf});
    checkOutput({tag, ".ill"},    {31'd0, bus.illegal},       {31'd0, ill});
    checkOutput({tag, ".br"},     {31'd0, bus.branch_taken},  {31'd0, bt});
    checkOutput({tag, ".rd"},     {27'd0, bus.rd_out},        {27'd0, rd});
    checkOutput({tag, ".rw"},     {31'd0, bus.reg_write_out}, {31'd0, rw});
  endtask

  // Drives one cycle of inputs and returns #1 after the capturing edge.
  task automatic applyStimulus(input logic [3:0] ctrl, input logic [31:0] a,
                               input logic [31:0] b, input logic beq, input logic bne,
                               input logic [4:0] rd, input logic rw, input logic valid,
                               input logic stl, input logic fl);
    bus.alu_ctrl     = ctrl;
    bus.op_a         = a;
    bus.op_b         = b;
    bus.is_beq       = beq;
    bus.is_bne       = bne;
    bus.rd_in        = rd;
    bus.reg_write_in = rw;
    bus.in_valid     = valid;
    bus.stall        = stl;
    bus.flush        = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    reset = 1'b1;
    bus.alu_ctrl = 4'd0; bus.op_a = '0; bus.op_b = '0; bus.is_beq = 1'b0;
    bus.is_bne = 1'b0; bus.rd_in = '0; bus.reg_write_in = 1'b0;
    bus.in_valid = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expectAll("reset", 0, 32'h0, 0, 0, 0, 0, 5'd0, 0);
    reset = 1'b0;

    applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'h1, 0, 0, 5'd5, 1, 1, 0, 0);
    expectAll("addOvf", 1, 32'h8000_0000, 0, 1, 0, 0, 5'd5, 0);

    applyStimulus(4'b0001, 32'd5, 32'd7, 0, 0, 5'd6, 1, 1, 0, 0);
    expectAll("sub", 1, 32'hFFFF_FFFE, 0, 0, 0, 0, 5'd6, 1);

    applyStimulus(4'b0110, 32'h8000_0000, 32'h1, 0, 0, 5'd7, 1, 1, 0, 0);
    expectAll("sltOvf", 1, 32'h1, 0, 0, 0, 0, 5'd7, 1);

    applyStimulus(4'b0110, 32'h1, 32'h8000_0000, 0, 0, 5'd8, 1, 1, 0, 0);
    expectAll("sltSwap", 1, 32'h0, 1, 0, 0, 0, 5'd8, 1);

    applyStimulus(4'b0101, 32'h0, 32'h0, 0, 0, 5'd9, 1, 1, 0, 0);
    expectAll("nor", 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 5'd9, 1);

    applyStimulus(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 5'd10, 1, 1, 0, 0);
    checkOutput("and", bus.alu_result, 32'h0000_F000);
    applyStimulus(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 5'd10, 1, 1, 0, 0);
    checkOutput("or", bus.alu_result, 32'h0000_FFF0);
    applyStimulus(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 0, 0, 5'd10, 1, 1, 0, 0);
    checkOutput("xor", bus.alu_result, 32'h0000_0FF0);

    applyStimulus(4'b0001, 32'h1234, 32'h1234, 1, 0, 5'd0, 0, 1, 0, 0);
    expectAll("beqTaken", 1, 32'h0, 1, 0, 0, 1, 5'd0, 0);
    applyStimulus(4'b0001, 32'h1234, 32'h1234, 0, 1, 5'd0, 0, 1, 0, 0);
    expectAll("bneNot", 1, 32'h0, 1, 0, 0, 0, 5'd0, 0);
    applyStimulus(4'b0001, 32'd3, 32'd4, 0, 1, 5'd0, 0, 1, 0, 0);
    expectAll("bneTaken", 1, 32'hFFFF_FFFF, 0, 0, 0, 1, 5'd0, 0);
    applyStimulus(4'b0001, 32'd1, 32'd1, 1, 1, 5'd0, 0, 1, 0, 0);
    expectAll("bothBr", 1, 32'h0, 1, 0, 1, 0, 5'd0, 0);

    applyStimulus(4'b0000, 32'd2, 32'd3, 0, 0, 5'd3, 1, 1, 0, 0);
    expectAll("add", 1, 32'd5, 0, 0, 0, 0, 5'd3, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0001, 32'd100 + i, 32'd1, 0, 0, 5'd12, 0, (i != 1), 1, 0);
      expectAll($sformatf("stall%0d", i), 1, 32'd5, 0, 0, 0, 0, 5'd3, 1);
    end
    applyStimulus(4'b0000, 32'd9, 32'd9, 0, 0, 5'd4, 1, 1, 1, 1);
    expectAll("stallFlush", 0, 32'h0, 0, 0, 0, 0, 5'd0, 0);

    applyStimulus(4'b1010, 32'd8, 32'd9, 0, 0, 5'd11, 1, 1, 0, 0);
    expectAll("illegal", 1, 32'h0, 1, 0, 1, 0, 5'd11, 0);
    applyStimulus(4'b1010, 32'd8, 32'd9, 0, 0, 5'd11, 1, 0, 0, 0);
    expectAll("bubble", 0, 32'h0, 0, 0, 0, 0, 5'd0, 0);

    // Asynchronous reset between edges while a valid result is held.
    applyStimulus(4'b0000, 32'd20, 32'd22, 0, 0, 5'd13, 1, 1, 0, 0);
    expectAll("preReset", 1, 32'd42, 0, 0, 0, 0, 5'd13, 1);
    #2;
    reset = 1'b1;
    #1;
    expectAll("asyncReset", 0, 32'h0, 0, 0, 0, 0, 5'd0, 0);
    #1;
    reset = 1'b0;
    applyStimulus(4'b0001, 32'd10, 32'd4, 0, 0, 5'd14, 1, 1, 0, 0);
    expectAll("postReset", 1, 32'd6, 0, 0, 0, 0, 5'd14, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
